// File: rtl/bus_timer_slave_pkg.sv
// Shared bus constants and timer register map for the bus timer slave.
// Register indices, control bit positions and strobe polarities live here.
package bus_timer_slave_pkg;

  localparam int unsigned WORD_DATA_W  = 32;
  localparam int unsigned TIMER_ADDR_W = 2;

  // Access direction on the rw line.
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Active-low strobe levels.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef logic [WORD_DATA_W-1:0] word_t;

  typedef enum logic [TIMER_ADDR_W-1:0] {
    TimerCtrl  = 2'd0,
    TimerIntr  = 2'd1,
    TimerExpr  = 2'd2,
    TimerCount = 2'd3
  } timer_reg_e;

  localparam int unsigned CTRL_START_BIT    = 0;
  localparam int unsigned CTRL_PERIODIC_BIT = 1;
  localparam int unsigned INTR_EXPIRED_BIT  = 0;

endpackage

// File: rtl/bus_timer_slave_if.sv
// Slave-side bus bundle for the timer: strobes, address, data and the
// active-low ready.
interface bus_timer_slave_if;
  import bus_timer_slave_pkg::*;

  logic                    cs_;
  logic                    as_;
  logic                    rw;
  logic [TIMER_ADDR_W-1:0] addr;
  word_t                   wr_data;
  word_t                   rd_data;
  logic                    rdy_;

  modport master (
    output cs_,
    output as_,
    output rw,
    output addr,
    output wr_data,
    input  rd_data,
    input  rdy_
  );

  modport slave (
    input  cs_,
    input  as_,
    input  rw,
    input  addr,
    input  wr_data,
    output rd_data,
    output rdy_
  );

endinterface

// File: rtl/bus_timer_slave.sv
// Programmable 32-bit timer on the system bus: one-shot or periodic expiry,
// level interrupt, single-cycle bus response with no wait states.
module bus_timer_slave
  import bus_timer_slave_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  bus_timer_slave_if.slave bus,
  output logic             irq
);

  logic       access;
  logic       wr_en;
  logic       rd_en;
  timer_reg_e reg_sel;

  assign access  = (bus.cs_ == ENABLE_) && (bus.as_ == ENABLE_);
  assign wr_en   = access && (bus.rw == WRITE);
  assign rd_en   = access && (bus.rw == READ);
  assign reg_sel = timer_reg_e'(bus.addr);

  logic  start_q, start_d;
  logic  periodic_q, periodic_d;
  logic  expired_q, expired_d;
  word_t expr_q, expr_d;
  word_t count_q, count_d;
  logic  expire;

  assign expire = start_q && (count_q == expr_q);

  // Read mux sees pre-edge register values, so reads return state at the accepting edge.
  word_t rd_val;

  always_comb begin
    rd_val = '0;
    unique case (reg_sel)
      TimerCtrl: begin
        rd_val[CTRL_START_BIT]    = start_q;
        rd_val[CTRL_PERIODIC_BIT] = periodic_q;
      end
      TimerIntr:  rd_val[INTR_EXPIRED_BIT] = expired_q;
      TimerExpr:  rd_val = expr_q;
      TimerCount: rd_val = count_q;
      default:    rd_val = '0;
    endcase
  end

  // Bus response: ready strobe and read data are valid for exactly one cycle.
  word_t rd_data_q;
  logic  rdy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
      rdy_q     <= DISABLE_;
    end else begin
      rdy_q     <= access ? ENABLE_ : DISABLE_;
      rd_data_q <= rd_en ? rd_val : '0;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rdy_    = rdy_q;

  // Timer next state; later assignments take priority over earlier ones.
  always_comb begin
    start_d    = start_q;
    periodic_d = periodic_q;
    expired_d  = expired_q;
    expr_d     = expr_q;
    count_d    = count_q;

    if (start_q) begin
      count_d = count_q + word_t'(1);
    end

    if (expire) begin
      count_d   = '0;
      expired_d = 1'b1;
      if (!periodic_q) begin
        start_d = 1'b0;
      end
    end

    if (wr_en) begin
      unique case (reg_sel)
        TimerCtrl: begin
          start_d    = bus.wr_data[CTRL_START_BIT];
          periodic_d = bus.wr_data[CTRL_PERIODIC_BIT];
        end
        TimerIntr: begin
          // A same-edge expiry must not be lost to a software clear.
          if (!expire) begin
            expired_d = bus.wr_data[INTR_EXPIRED_BIT];
          end
        end
        TimerExpr:  expr_d  = bus.wr_data;
        TimerCount: count_d = bus.wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q    <= 1'b0;
      periodic_q <= 1'b0;
      expired_q  <= 1'b0;
      expr_q     <= '0;
      count_q    <= '0;
    end else begin
      start_q    <= start_d;
      periodic_q <= periodic_d;
      expired_q  <= expired_d;
      expr_q     <= expr_d;
      count_q    <= count_d;
    end
  end

  assign irq = expired_q;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Directed self-checking bench for bus_timer_slave: register table plus
// timed sequences for expiry, priority, back-to-back and reset corners.
module tb_bus_timer_slave;
  import bus_timer_slave_pkg::*;

  logic clk;
  logic reset;
  logic irq;

  bus_timer_slave_if bus_if ();

  bus_timer_slave dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after an edge; the strobe is accepted at the next edge and
  // the response is sampled #1 after it. Consecutive calls are back-to-back.
  task automatic access(input logic rw_v, input logic [1:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input string name);
    bus_if.cs_     = 1'b0;
    bus_if.as_     = 1'b0;
    bus_if.rw      = rw_v;
    bus_if.addr    = a;
    bus_if.wr_data = wd;
    @(posedge clk);
    #1;
    chk({name, " rdy_"}, 32'(bus_if.rdy_), 32'd0);
    chk({name, " rd_data"}, bus_if.rd_data, exp_rd);
    bus_if.cs_ = 1'b1;
    bus_if.as_ = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd, input string name);
    access(WRITE, a, wd, 32'd0, name);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    access(READ, a, 32'd0, exp, name);
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int rise;

    vecs[0]  = '{READ,  TimerCtrl,  32'h0,         32'h0};
    vecs[1]  = '{READ,  TimerIntr,  32'h0,         32'h0};
    vecs[2]  = '{READ,  TimerCount, 32'h0,         32'h0};
    vecs[3]  = '{WRITE, TimerExpr,  32'hDEADBEEF,  32'h0};
    vecs[4]  = '{READ,  TimerExpr,  32'h0,         32'hDEADBEEF};
    vecs[5]  = '{WRITE, TimerCount, 32'h12345678,  32'h0};
    vecs[6]  = '{READ,  TimerCount, 32'h0,         32'h12345678};
    vecs[7]  = '{WRITE, TimerCtrl,  32'hFFFFFFFE,  32'h0};
    vecs[8]  = '{READ,  TimerCtrl,  32'h0,         32'h2};
    vecs[9]  = '{WRITE, TimerIntr,  32'hFFFFFFFF,  32'h0};
    vecs[10] = '{READ,  TimerIntr,  32'h0,         32'h1};
    vecs[11] = '{WRITE, TimerIntr,  32'hFFFFFFFE,  32'h0};
    vecs[12] = '{READ,  TimerIntr,  32'h0,         32'h0};
    vecs[13] = '{WRITE, TimerCtrl,  32'h0,         32'h0};
    vecs[14] = '{READ,  TimerCtrl,  32'h0,         32'h0};

    bus_if.cs_     = 1'b1;
    bus_if.as_     = 1'b1;
    bus_if.rw      = READ;
    bus_if.addr    = 2'd0;
    bus_if.wr_data = 32'd0;
    reset          = 1'b0;

    #12;
    chk("reset rdy_", 32'(bus_if.rdy_), 32'd1);
    chk("reset rd_data", bus_if.rd_data, 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // First read after reset: ready high before, low for one cycle, then high.
    chk("pre-access rdy_", 32'(bus_if.rdy_), 32'd1);
    rd(TimerExpr, 32'h0, "first read EXPR");
    idle(1);
    chk("post-access rdy_", 32'(bus_if.rdy_), 32'd1);
    chk("post-access rd_data", bus_if.rd_data, 32'd0);

    for (int i = 0; i < 15; i++) begin
      access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // One-shot: EXPR=5, start at edge E0, expiry sets irq after E6.
    wr(TimerExpr, 32'd5, "oneshot EXPR");
    wr(TimerCount, 32'd0, "oneshot COUNT");
    wr(TimerCtrl, 32'h1, "oneshot CTRL");
    rise = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (irq && rise == 0) rise = i;
    end
    chk("oneshot irq rise cycle", 32'(rise), 32'd6);
    rd(TimerCount, 32'd0, "oneshot COUNT after");
    rd(TimerCtrl, 32'd0, "oneshot CTRL after");
    rd(TimerIntr, 32'd1, "oneshot INTR after");
    wr(TimerIntr, 32'd0, "oneshot clear");
    chk("oneshot irq cleared", 32'(irq), 32'd0);

    // Periodic: EXPR=3, expiries at E4, E8, E12, E16.
    wr(TimerExpr, 32'd3, "periodic EXPR");
    wr(TimerCtrl, 32'h3, "periodic CTRL");
    rise = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (irq && rise == 0) rise = i;
    end
    chk("periodic first rise", 32'(rise), 32'd4);
    wr(TimerIntr, 32'd0, "periodic clear");
    chk("periodic irq low next cycle", 32'(irq), 32'd0);
    rise = 0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      if (irq && rise == 0) rise = i;
    end
    chk("periodic second rise", 32'(rise), 32'd3);
    rd(TimerCount, 32'd0, "periodic COUNT 0");
    rd(TimerCount, 32'd1, "periodic COUNT 1");
    rd(TimerCount, 32'd2, "periodic COUNT 2");
    rd(TimerCount, 32'd3, "periodic COUNT 3");
    // Clear of INTR lands on the same edge as the E16 expiry.
    idle(3);
    wr(TimerIntr, 32'd0, "same-edge clear");
    chk("same-edge irq stays", 32'(irq), 32'd1);
    rd(TimerIntr, 32'd1, "same-edge INTR");
    wr(TimerCtrl, 32'd0, "periodic stop");

    // Back-to-back reads of the whole map.
    wr(TimerCount, 32'h55, "b2b COUNT");
    wr(TimerExpr, 32'h12345678, "b2b EXPR");
    wr(TimerIntr, 32'h1, "b2b INTR");
    wr(TimerCtrl, 32'h2, "b2b CTRL");
    rd(TimerCtrl, 32'h2, "b2b rd CTRL");
    rd(TimerIntr, 32'h1, "b2b rd INTR");
    rd(TimerExpr, 32'h12345678, "b2b rd EXPR");
    rd(TimerCount, 32'h55, "b2b rd COUNT");
    idle(1);
    chk("b2b rdy_ released", 32'(bus_if.rdy_), 32'd1);

    // Strobes with cs_ or as_ inactive must be ignored.
    bus_if.cs_     = 1'b1;
    bus_if.as_     = 1'b0;
    bus_if.rw      = WRITE;
    bus_if.addr    = TimerExpr;
    bus_if.wr_data = 32'h0;
    @(posedge clk);
    #1;
    chk("cs_ high rdy_", 32'(bus_if.rdy_), 32'd1);
    bus_if.cs_     = 1'b0;
    bus_if.as_     = 1'b1;
    bus_if.addr    = TimerCtrl;
    bus_if.wr_data = 32'h1;
    @(posedge clk);
    #1;
    chk("as_ high rdy_", 32'(bus_if.rdy_), 32'd1);
    bus_if.cs_ = 1'b1;
    idle(2);
    rd(TimerExpr, 32'h12345678, "ignored EXPR");
    rd(TimerCtrl, 32'h2, "ignored CTRL");
    rd(TimerCount, 32'h55, "ignored COUNT");

    // EXPR=0 expires every cycle, beating a same-edge INTR clear each time.
    wr(TimerCount, 32'd0, "zero COUNT");
    wr(TimerExpr, 32'd0, "zero EXPR");
    wr(TimerIntr, 32'd0, "zero INTR");
    wr(TimerCtrl, 32'h3, "zero CTRL");
    wr(TimerIntr, 32'd0, "zero clear");
    rd(TimerIntr, 32'd1, "zero INTR set");
    rd(TimerCount, 32'd0, "zero COUNT held");
    chk("zero irq", 32'(irq), 32'd1);
    wr(TimerCtrl, 32'd0, "zero stop");

    // Counter wraps from all-ones to zero.
    wr(TimerExpr, 32'd5, "wrap EXPR");
    wr(TimerCount, 32'hFFFFFFFF, "wrap COUNT");
    wr(TimerCtrl, 32'h1, "wrap CTRL");
    rd(TimerCount, 32'hFFFFFFFF, "wrap COUNT max");
    rd(TimerCount, 32'd0, "wrap COUNT zero");
    wr(TimerCtrl, 32'd0, "wrap stop");

    // Reset in the middle of an accepted read with the timer running.
    wr(TimerExpr, 32'd100, "abort EXPR");
    wr(TimerIntr, 32'd1, "abort INTR");
    wr(TimerCtrl, 32'h1, "abort CTRL");
    bus_if.cs_  = 1'b0;
    bus_if.as_  = 1'b0;
    bus_if.rw   = READ;
    bus_if.addr = TimerCtrl;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    bus_if.cs_ = 1'b1;
    bus_if.as_ = 1'b1;
    #1;
    chk("abort rdy_", 32'(bus_if.rdy_), 32'd1);
    chk("abort rd_data", bus_if.rd_data, 32'd0);
    chk("abort irq", 32'(irq), 32'd0);
    idle(1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort no late rdy_", 32'(bus_if.rdy_), 32'd1);
    idle(1);
    chk("abort still idle", 32'(bus_if.rdy_), 32'd1);
    rd(TimerCtrl, 32'd0, "abort CTRL after");
    rd(TimerCount, 32'd0, "abort COUNT after");
    rd(TimerExpr, 32'd0, "abort EXPR after");
    rd(TimerIntr, 32'd0, "abort INTR after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
